// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU and its issue/complete sequencer:
//   FuncOp codes, flag bit positions, flag vector width, sequencer state
//   encoding and the helper that merges the flags of a two-pass wide op.
//   No ports (package).

package alu_pkg;

    localparam int FLAGS_WIDTH = 4;

    // Flag vector bit positions
    localparam int Z_BIT = 0;
    localparam int C_BIT = 1;
    localparam int N_BIT = 2;
    localparam int V_BIT = 3;

    // ALU function codes; the sequencer passes any code through untouched
    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7
    } func_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } seq_state_e;

    // Wide result flags: zero only if both halves were zero, the rest
    // (carry, sign, overflow) belong to the upper pass.
    function automatic logic [FLAGS_WIDTH-1:0] chain_flags(
        input logic [FLAGS_WIDTH-1:0] lo_flags,
        input logic [FLAGS_WIDTH-1:0] hi_flags
    );
        logic [FLAGS_WIDTH-1:0] merged;
        merged        = hi_flags;
        merged[Z_BIT] = lo_flags[Z_BIT] & hi_flags[Z_BIT];
        return merged;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Issue/complete front end for an external combinational ALU. Accepts one
//   request at a time, runs one ALU pass (narrow) or two carry-chained passes
//   (wide, 2*DataWidth), then holds the result until the consumer takes it.
//   Owns the architectural flags register that feeds the ALU carry-in.
//
// Ports
//   Clock, Reset_N             clock (rising edge), async active-low reset
//   ReqValid/ReqReady          request handshake
//   ReqOp, ReqWide, ReqA, ReqB request op code, width select, operands
//   RspValid/RspReady          response handshake
//   RspY, RspFlags             result and result flags
//   Flags                      architectural flags register
//   AluA, AluB, AluOp,
//   AluIFlags                  drive to the ALU
//   AluY, AluOFlags            result from the ALU

module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DataWidth = 16
) (
    input  logic                     Clock,
    input  logic                     Reset_N,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [3:0]               ReqOp,
    input  logic                     ReqWide,
    input  logic [2*DataWidth-1:0]   ReqA,
    input  logic [2*DataWidth-1:0]   ReqB,
    output logic                     RspValid,
    input  logic                     RspReady,
    output logic [2*DataWidth-1:0]   RspY,
    output logic [FLAGS_WIDTH-1:0]   RspFlags,
    output logic [FLAGS_WIDTH-1:0]   Flags,
    output logic [DataWidth-1:0]     AluA,
    output logic [DataWidth-1:0]     AluB,
    output logic [3:0]               AluOp,
    output logic [FLAGS_WIDTH-1:0]   AluIFlags,
    input  logic [DataWidth-1:0]     AluY,
    input  logic [FLAGS_WIDTH-1:0]   AluOFlags
);

    seq_state_e                 state_r;
    seq_state_e                 state_s;

    logic                       wide_r;
    logic [DataWidth-1:0]       a_hi_r;
    logic [DataWidth-1:0]       b_hi_r;
    logic [DataWidth-1:0]       y_lo_r;
    logic [FLAGS_WIDTH-1:0]     flags_lo_r;
    logic [2*DataWidth-1:0]     rsp_y_r;
    logic [FLAGS_WIDTH-1:0]     rsp_flags_r;
    logic [FLAGS_WIDTH-1:0]     flags_r;
    logic                       req_ready_r;
    logic                       rsp_valid_r;
    logic [DataWidth-1:0]       alu_a_r;
    logic [DataWidth-1:0]       alu_b_r;
    logic [3:0]                 alu_op_r;
    logic [FLAGS_WIDTH-1:0]     alu_iflags_r;

    // Next-state logic of the issue/complete FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ReqValid) begin
                    state_s = ST_LO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (wide_r) begin
                    state_s = ST_HI;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_HI: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (RspReady) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand, result, flags and ALU-drive registers. ALU inputs are loaded
    // one edge early so they are already valid for the pass they belong to.
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            wide_r       <= 1'b0;
            a_hi_r       <= {DataWidth{1'b0}};
            b_hi_r       <= {DataWidth{1'b0}};
            y_lo_r       <= {DataWidth{1'b0}};
            flags_lo_r   <= {FLAGS_WIDTH{1'b0}};
            rsp_y_r      <= {(2*DataWidth){1'b0}};
            rsp_flags_r  <= {FLAGS_WIDTH{1'b0}};
            flags_r      <= {FLAGS_WIDTH{1'b0}};
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            alu_a_r      <= {DataWidth{1'b0}};
            alu_b_r      <= {DataWidth{1'b0}};
            alu_op_r     <= 4'h0;
            alu_iflags_r <= {FLAGS_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ReqValid) begin
                        wide_r       <= ReqWide;
                        a_hi_r       <= ReqA[2*DataWidth-1:DataWidth];
                        b_hi_r       <= ReqB[2*DataWidth-1:DataWidth];
                        alu_a_r      <= ReqA[DataWidth-1:0];
                        alu_b_r      <= ReqB[DataWidth-1:0];
                        alu_op_r     <= ReqOp;
                        alu_iflags_r <= flags_r;
                        req_ready_r  <= 1'b0;
                    end
                end
                ST_LO: begin
                    y_lo_r     <= AluY;
                    flags_lo_r <= AluOFlags;
                    if (wide_r) begin
                        // Upper pass: carry/borrow-in comes from the lower pass
                        alu_a_r      <= a_hi_r;
                        alu_b_r      <= b_hi_r;
                        alu_iflags_r <= AluOFlags;
                    end else begin
                        rsp_y_r      <= {{DataWidth{1'b0}}, AluY};
                        rsp_flags_r  <= AluOFlags;
                        flags_r      <= AluOFlags;
                        rsp_valid_r  <= 1'b1;
                        alu_a_r      <= {DataWidth{1'b0}};
                        alu_b_r      <= {DataWidth{1'b0}};
                        alu_op_r     <= 4'h0;
                        alu_iflags_r <= {FLAGS_WIDTH{1'b0}};
                    end
                end
                ST_HI: begin
                    rsp_y_r      <= {AluY, y_lo_r};
                    rsp_flags_r  <= chain_flags(flags_lo_r, AluOFlags);
                    flags_r      <= chain_flags(flags_lo_r, AluOFlags);
                    rsp_valid_r  <= 1'b1;
                    alu_a_r      <= {DataWidth{1'b0}};
                    alu_b_r      <= {DataWidth{1'b0}};
                    alu_op_r     <= 4'h0;
                    alu_iflags_r <= {FLAGS_WIDTH{1'b0}};
                end
                ST_RESP: begin
                    if (RspReady) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_r  <= 1'b0;
                    req_ready_r  <= 1'b1;
                    alu_a_r      <= {DataWidth{1'b0}};
                    alu_b_r      <= {DataWidth{1'b0}};
                    alu_op_r     <= 4'h0;
                    alu_iflags_r <= {FLAGS_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign ReqReady  = req_ready_r;
    assign RspValid  = rsp_valid_r;
    assign RspY      = rsp_y_r;
    assign RspFlags  = rsp_flags_r;
    assign Flags     = flags_r;
    assign AluA      = alu_a_r;
    assign AluB      = alu_b_r;
    assign AluOp     = alu_op_r;
    assign AluIFlags = alu_iflags_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Bench for alu_sequencer: a 16-bit ALU model sits beside the DUT, a
//   per-cycle compare process checks the DUT against an operation-level
//   reference model, and directed cases pin that model with literal values
//   before a randomized phase.

module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int DW = 16;

    logic        Clock = 1'b0;
    logic        Reset_N;
    logic        ReqValid;
    logic        ReqReady;
    logic [3:0]  ReqOp;
    logic        ReqWide;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspY;
    logic [3:0]  RspFlags;
    logic [3:0]  Flags;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [3:0]  AluOp;
    logic [3:0]  AluIFlags;
    logic [15:0] AluY;
    logic [3:0]  AluOFlags;

    alu_sequencer #(.DataWidth(DW)) dut (
        .Clock(Clock), .Reset_N(Reset_N),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqWide(ReqWide),
        .ReqA(ReqA), .ReqB(ReqB),
        .RspValid(RspValid), .RspReady(RspReady), .RspY(RspY), .RspFlags(RspFlags),
        .Flags(Flags),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluIFlags(AluIFlags),
        .AluY(AluY), .AluOFlags(AluOFlags)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Combinational 16-bit ALU the sequencer drives
    always_comb begin
        logic [16:0] s;
        logic        c;
        logic        v;
        s = {1'b0, AluA};
        c = 1'b0;
        v = 1'b0;
        case (AluOp)
            OP_ADD: begin
                s = {1'b0, AluA} + {1'b0, AluB} + {16'd0, AluIFlags[C_BIT]};
                c = s[16];
                v = (AluA[15] == AluB[15]) && (s[15] != AluA[15]);
            end
            OP_SUB: begin
                s = {1'b0, AluA} - {1'b0, AluB} - {16'd0, AluIFlags[C_BIT]};
                c = s[16];
                v = (AluA[15] != AluB[15]) && (s[15] != AluA[15]);
            end
            OP_AND:  s = {1'b0, AluA & AluB};
            OP_OR:   s = {1'b0, AluA | AluB};
            OP_XOR:  s = {1'b0, AluA ^ AluB};
            default: s = {1'b0, AluA};
        endcase
        AluY      = s[15:0];
        AluOFlags = {v, s[15], c, (s[15:0] == 16'd0)};
    end

    // Whole-operation reference: the result of one op at its full width
    function automatic void ref_op(input logic [3:0] op, input logic wide,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] fin,
                                   output logic [31:0] y, output logic [3:0] f);
        longint unsigned m, top, aa, bb, r, cin;
        logic c, v, n;
        m   = wide ? 64'hFFFF_FFFF : 64'h0000_FFFF;
        top = wide ? 64'h8000_0000 : 64'h0000_8000;
        aa  = a & m;
        bb  = b & m;
        cin = {63'd0, fin[C_BIT]};
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                r = aa + bb + cin;
                c = (r > m);
                r = r & m;
                v = ((aa & top) == (bb & top)) && ((r & top) != (aa & top));
            end
            OP_SUB: begin
                c = (aa < bb + cin);
                r = (aa - bb - cin) & m;
                v = ((aa & top) != (bb & top)) && ((r & top) != (aa & top));
            end
            OP_AND:  r = aa & bb;
            OP_OR:   r = aa | bb;
            OP_XOR:  r = aa ^ bb;
            default: r = aa;
        endcase
        n = ((r & top) != 64'd0);
        y = r[31:0];
        f = {v, n, c, (r == 64'd0)};
    endfunction

    // Compare process: model bookkeeping driven by what the next edge sees
    logic        busy = 1'b0;
    int          acc_cyc = 0;
    int          lat_exp = 0;
    logic [31:0] exp_y;
    logic [3:0]  exp_f;
    logic [3:0]  mflags = 4'h0;
    logic [31:0] pend_a, pend_b;
    logic [3:0]  pend_op;

    always @(negedge Clock) begin
        int age;
        if (!Reset_N) begin
            busy   = 1'b0;
            mflags = 4'h0;
            chk("rst_req_ready", ReqReady, 32'd1);
            chk("rst_rsp_valid", RspValid, 32'd0);
            chk("rst_rsp_y", RspY, 32'd0);
            chk("rst_rsp_flags", RspFlags, 32'd0);
            chk("rst_flags", Flags, 32'd0);
            chk("rst_alu_a", AluA, 32'd0);
            chk("rst_alu_op", AluOp, 32'd0);
        end else begin
            age = cyc - acc_cyc + 1;
            if (busy && age >= lat_exp) begin
                chk("resp_valid", RspValid, 32'd1);
                chk("resp_ready_low", ReqReady, 32'd0);
                chk("resp_y", RspY, exp_y);
                chk("resp_flags", RspFlags, exp_f);
                chk("resp_arch_flags", Flags, exp_f);
            end else if (busy) begin
                chk("busy_valid_low", RspValid, 32'd0);
                chk("busy_ready_low", ReqReady, 32'd0);
                chk("busy_arch_flags", Flags, mflags);
                chk("busy_alu_op", AluOp, pend_op);
                if (age == 1) begin
                    chk("lo_alu_a", AluA, pend_a[15:0]);
                    chk("lo_alu_b", AluB, pend_b[15:0]);
                    chk("lo_alu_iflags", AluIFlags, mflags);
                end else begin
                    chk("hi_alu_a", AluA, pend_a[31:16]);
                    chk("hi_alu_b", AluB, pend_b[31:16]);
                end
            end else begin
                chk("idle_ready", ReqReady, 32'd1);
                chk("idle_valid_low", RspValid, 32'd0);
                chk("idle_arch_flags", Flags, mflags);
                chk("idle_alu_a", AluA, 32'd0);
                chk("idle_alu_op", AluOp, 32'd0);
                chk("idle_alu_iflags", AluIFlags, 32'd0);
            end
            if (busy && age >= lat_exp && RspReady) begin
                busy   = 1'b0;
                mflags = exp_f;
            end else if (!busy && ReqValid) begin
                ref_op(ReqOp, ReqWide, ReqA, ReqB, mflags, exp_y, exp_f);
                lat_exp = ReqWide ? 3 : 2;
                pend_a  = ReqA;
                pend_b  = ReqB;
                pend_op = ReqOp;
                acc_cyc = cyc + 1;
                busy    = 1'b1;
            end
        end
    end

    // One request/response; called and returns at posedge+#1
    task automatic do_op(input logic [3:0] op, input logic wide,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] y, output logic [3:0] f, output int lat);
        int n;
        ReqOp = op; ReqWide = wide; ReqA = a; ReqB = b;
        ReqValid = 1'b1;
        RspReady = 1'b0;
        n = 0;
        while (!ReqReady && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        chk("req_ready_wait", ReqReady, 32'd1);
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        lat = 1;
        while (!RspValid && lat < 10) begin
            @(posedge Clock); #1;
            lat++;
        end
        chk("rsp_valid_wait", RspValid, 32'd1);
        y = RspY;
        f = RspFlags;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock); #1;
            if (i == 1) begin
                ReqOp = OP_SUB; ReqWide = 1'b1; ReqA = 32'h5555_AAAA; ReqB = 32'h1234_5678;
                ReqValid = 1'b1;
            end
            if (i == 2) ReqValid = 1'b0;
            chk("bp_y_stable", RspY, y);
            chk("bp_flags_stable", RspFlags, f);
            chk("bp_ready_low", ReqReady, 32'd0);
        end
        RspReady = 1'b1;
        @(posedge Clock); #1;
        RspReady = 1'b0;
        chk("idle_next", ReqReady, 32'd1);
    endtask

    logic [31:0] y;
    logic [3:0]  f;
    int          lat;

    initial begin
        Reset_N = 1'b0; ReqValid = 1'b0; RspReady = 1'b0;
        ReqOp = 4'h0; ReqWide = 1'b0; ReqA = 32'h0; ReqB = 32'h0;
        repeat (2) @(posedge Clock);
        #1 Reset_N = 1'b1;
        @(posedge Clock); #1;

        do_op(OP_ADD, 1'b0, 32'h0000_0001, 32'h0000_0002, 0, y, f, lat);
        chk("t1_y", y, 32'h0000_0003);
        chk("t1_f", f, 32'h0);
        chk("t1_lat", lat, 32'd2);

        do_op(OP_ADD, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 0, y, f, lat);
        chk("t2_y", y, 32'h0001_0000);
        chk("t2_f", f, 32'h0);
        chk("t2_lat", lat, 32'd3);

        do_op(OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 0, y, f, lat);
        chk("t3_y", y, 32'h0000_0000);
        chk("t3_f", f, 32'h3);
        chk("t3_arch_flags", Flags, 32'h3);

        do_op(OP_AND, 1'b0, 32'h0000_1234, 32'h0000_00FF, 5, y, f, lat);
        chk("t4_y", y, 32'h0000_0034);
        chk("t4_f", f, 32'h0);

        // Reset while the upper pass is in progress
        ReqOp = OP_ADD; ReqWide = 1'b1; ReqA = 32'h1234_5678; ReqB = 32'h0F0F_F0F0;
        ReqValid = 1'b1;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        @(posedge Clock); #1;
        chk("pre_rst_ready", ReqReady, 32'd0);
        Reset_N = 1'b0;
        #1;
        chk("async_rst_valid", RspValid, 32'd0);
        chk("async_rst_ready", ReqReady, 32'd1);
        chk("async_rst_flags", Flags, 32'd0);
        chk("async_rst_alu_a", AluA, 32'd0);
        @(posedge Clock); #1;
        Reset_N = 1'b1;
        repeat (3) begin
            @(posedge Clock); #1;
            chk("no_rsp_after_rst", RspValid, 32'd0);
        end

        do_op(OP_XOR, 1'b0, 32'h0000_FF00, 32'h0000_0FF0, 0, y, f, lat);
        chk("t5_y", y, 32'h0000_F0F0);
        chk("t5_f", f, 32'h4);

        do_op(OP_ADD, 1'b0, 32'h0000_FFFF, 32'h0000_0001, 0, y, f, lat);
        chk("t6_y", y, 32'h0000_0000);
        chk("t6_f", f, 32'h3);
        do_op(OP_ADD, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, y, f, lat);
        chk("t7_y", y, 32'h0000_0001);
        chk("t7_f", f, 32'h0);

        // Randomized traffic, including upper-half garbage on narrow ops
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] pick_a, pick_b;
            @(posedge Clock); #1;
            if ($urandom_range(0, 399) == 0) begin
                Reset_N = 1'b0;
            end else begin
                Reset_N = 1'b1;
            end
            ReqValid = ($urandom_range(0, 1) == 1);
            RspReady = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: ReqOp = OP_ADD;
                1: ReqOp = OP_SUB;
                2: ReqOp = OP_AND;
                3: ReqOp = OP_OR;
                4: ReqOp = OP_XOR;
                default: ReqOp = 4'hF;
            endcase
            ReqWide = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 5))
                0: pick_a = 32'h0000_0000;
                1: pick_a = 32'hFFFF_FFFF;
                2: pick_a = 32'h0000_FFFF;
                3: pick_a = 32'h8000_0000;
                default: pick_a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: pick_b = 32'h0000_0001;
                1: pick_b = 32'hFFFF_FFFF;
                2: pick_b = 32'h0000_8000;
                default: pick_b = $urandom;
            endcase
            ReqA = pick_a;
            ReqB = pick_b;
        end
        Reset_N  = 1'b1;
        ReqValid = 1'b0;
        RspReady = 1'b1;
        repeat (10) @(posedge Clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
